// File: rtl/arb4_rr_v.sv
// -----------------------------------------------------------------------------
// arb4_rr_v -- four-requester round-robin arbiter with bounded grant tenure.
//
// Turns four level-sensitive request lines into one registered one-hot grant.
// A tenure ends on i_done, on withdrawal of the granted request, or after
// HOLD_MAX grant cycles (HOLD_MAX = 0 disables the timeout). Every release is
// followed by one idle turnaround cycle, and the priority pointer moves to the
// requester just after the one released, so no requester starves.
//
// Ports
//   i_clk      in   1  clock, rising edge
//   i_rst_n    in   1  asynchronous active-low reset
//   i_req      in   4  request lines, bit n = requester n
//   i_done     in   1  end of transfer from the grantee (ignored while idle)
//   o_gnt      out  4  registered one-hot grant, zero when idle
//   o_gnt_idx  out  2  binary index of the grantee, zero when idle
//   o_busy     out  1  a grant is held
//   o_any_req  out  1  combinational OR of i_req
//   o_timeout  out  1  one-cycle pulse after a release caused only by timeout
//
// Also contains or4, the 4-input OR component that qualifies arbitration.
// -----------------------------------------------------------------------------

// 4-input OR component.
//   a  in   4  inputs
//   y  out  1  OR of all inputs
module or4 (
  input  logic [3:0] a,
  output logic       y
);

  assign y = |a;

endmodule

// State table
//   state | meaning
//   IDLE  | no grant held; arbitrate among live requests on the next edge
//   GRANT | one requester owns the grant until done, withdrawal or timeout
module arb4_rr_v #(
  parameter int HOLD_MAX = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  input  logic       i_done,
  output logic [3:0] o_gnt,
  output logic [1:0] o_gnt_idx,
  output logic       o_busy,
  output logic       o_any_req,
  output logic       o_timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Timeout fires in the last allowed grant cycle, when cnt reaches HOLD_MAX-1.
  localparam bit         TO_EN    = (HOLD_MAX != 0);
  localparam logic [7:0] CNT_LAST = TO_EN ? 8'(HOLD_MAX - 1) : 8'd0;

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] cnt;

  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;

  logic       rel_done;
  logic       rel_wd;
  logic       rel_to;
  logic       release_now;

  or4 u_any_req (
    .a (i_req),
    .y (o_any_req)
  );

  // Rotating priority search starting at ptr.
  always_comb begin
    winner = ptr;
    cand   = ptr;
    found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && i_req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign rel_done    = i_done;
  assign rel_wd      = ~i_req[o_gnt_idx];
  assign rel_to      = TO_EN && (cnt == CNT_LAST);
  assign release_now = rel_done | rel_wd | rel_to;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= 8'd0;
      o_gnt     <= 4'd0;
      o_gnt_idx <= 2'd0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (o_any_req) begin
            state     <= GRANT;
            o_gnt     <= 4'b0001 << winner;
            o_gnt_idx <= winner;
            o_busy    <= 1'b1;
            cnt       <= 8'd0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state     <= IDLE;
            o_gnt     <= 4'd0;
            o_gnt_idx <= 2'd0;
            o_busy    <= 1'b0;
            ptr       <= o_gnt_idx + 2'd1;
            cnt       <= 8'd0;
            // A timeout coinciding with done or withdrawal counts as normal.
            o_timeout <= rel_to & ~rel_done & ~rel_wd;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb4_rr_v.sv
module tb_arb4_rr_v;

  localparam int HOLD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = 4'd0;
  logic       done  = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       any_req;
  logic       tmo;

  int n_tests = 0;
  int n_fail  = 0;
  int n_tmo_seen = 0;

  arb4_rr_v #(.HOLD_MAX(HOLD)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_done    (done),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx),
    .o_busy    (busy),
    .o_any_req (any_req),
    .o_timeout (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  // Behavioural model: who owns the grant, for how many cycles, and where the
  // round-robin search starts next.
  int m_busy, m_owner, m_ptr, m_held, m_to;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    bit rd, rw, rt;
    if (m_busy != 0) begin
      rd = d;
      rw = !r[m_owner];
      rt = (HOLD > 0) && (m_held == HOLD);
      if (rd || rw || rt) begin
        m_ptr   = (m_owner + 1) % 4;
        m_to    = (rt && !rd && !rw) ? 1 : 0;
        m_busy  = 0;
        m_owner = 0;
        m_held  = 0;
      end else begin
        m_held++;
        m_to = 0;
      end
    end else begin
      m_to = 0;
      if (r != 4'd0) begin
        for (int k = 3; k >= 0; k--) begin
          if (r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        end
        m_busy = 1;
        m_held = 1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m_gnt",     int'(gnt),     (m_busy != 0) ? (1 << m_owner) : 0);
    chk("m_idx",     int'(gnt_idx), m_owner);
    chk("m_busy",    int'(busy),    m_busy);
    chk("m_timeout", int'(tmo),     m_to);
    chk("m_any_req", int'(any_req), (req != 4'd0) ? 1 : 0);
  endtask

  // Advance one clock: model consumes the inputs seen at this edge, then the
  // outputs are sampled 1 ns after the edge.
  task automatic tick();
    if (rst_n) model_step(req, done);
    else       model_reset();
    @(posedge clk);
    #1;
    if (tmo) n_tmo_seen++;
    compare_model();
  endtask

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t rot[9];

  initial begin
    // Rotation with i_req=1111 and done pulsed in each grant cycle.
    // Entry 5 also pulses done while idle, which must be ignored.
    rot[0] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    rot[1] = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    rot[2] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    rot[3] = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    rot[4] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    rot[5] = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
    rot[6] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    rot[7] = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    rot[8] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};

    model_reset();

    // Reset with all requests active.
    req = 4'b1111; rst_n = 1'b0; done = 1'b0;
    #2;
    chk("rst_gnt",     int'(gnt),     0);
    chk("rst_busy",    int'(busy),    0);
    chk("rst_idx",     int'(gnt_idx), 0);
    chk("rst_tmo",     int'(tmo),     0);
    chk("rst_any_req", int'(any_req), 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("first_gnt", int'(gnt), 4'b0001);

    for (int i = 0; i < 9; i++) begin
      req  = rot[i].req;
      done = rot[i].done;
      tick();
      chk("rot_gnt",  int'(gnt),     int'(rot[i].gnt));
      chk("rot_idx",  int'(gnt_idx), int'(rot[i].idx));
      chk("rot_busy", int'(busy),    int'(rot[i].busy));
      chk("rot_tmo",  int'(tmo),     int'(rot[i].to));
    end
    done = 1'b0;

    // Timeout: ptr=1, only requester 2 asks and never finishes.
    req = 4'b0100;
    for (int k = 0; k < HOLD; k++) begin
      tick();
      chk("to_hold_gnt", int'(gnt), 4'b0100);
      chk("to_hold_tmo", int'(tmo), 0);
    end
    tick();
    chk("to_rel_gnt", int'(gnt), 0);
    chk("to_pulse",   int'(tmo), 1);
    tick();
    chk("to_regnt", int'(gnt), 4'b0100);
    chk("to_clear", int'(tmo), 0);

    // Done in the last allowed cycle: normal release, no timeout pulse.
    for (int k = 1; k < HOLD; k++) begin
      tick();
      chk("sim_hold_gnt", int'(gnt), 4'b0100);
    end
    done = 1'b1;
    tick();
    chk("sim_rel_gnt", int'(gnt), 0);
    chk("sim_no_tmo",  int'(tmo), 0);
    done = 1'b0;

    // Withdrawal and skip; ptr=3 here so requester 1 wins with 0010.
    req = 4'b0010;
    tick();
    chk("wd_gnt1", int'(gnt), 4'b0010);
    req = 4'b1010;
    tick();
    chk("wd_no_preempt", int'(gnt), 4'b0010);
    req = 4'b1000;
    tick();
    chk("wd_rel_gnt", int'(gnt), 0);
    chk("wd_rel_tmo", int'(tmo), 0);
    tick();
    chk("wd_next_gnt", int'(gnt), 4'b1000);
    chk("wd_next_idx", int'(gnt_idx), 3);

    // Build ptr=2 while requester 1 holds the grant.
    done = 1'b1;
    tick();
    done = 1'b0; req = 4'b0010;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("ar_pre_gnt", int'(gnt), 4'b0010);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_gnt",  int'(gnt),     0);
    chk("ar_busy", int'(busy),    0);
    chk("ar_idx",  int'(gnt_idx), 0);
    req = 4'b1110;
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_ptr0_gnt", int'(gnt), 4'b0010);

    // Randomized traffic against the model, with occasional mid-cycle resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      end
      done = ($urandom_range(7) == 0);
      if ($urandom_range(299) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_model();
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    chk("timeouts_exercised", (n_tmo_seen > 1) ? 1 : 0, 1);

    req = 4'd0; done = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
